ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/arm_pipe_pkg.sv | 29 ++
 rtl/cond_check.sv | 40 ++++
 rtl/ex_mem_stage.sv | 107 ++++++++++
 tb/tb_ex_mem_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared pipeline constants: ARM condition codes, NZCV bit positions and datapath widths.
package arm_pipe_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned REG_WIDTH  = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator against an NZCV value.
module cond_check
    import arm_pipe_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with conditional-execution gating and the architectural NZCV register.
// Optional feature macro: EX_COND_EXEC_EN (defined = condition codes applied, undefined = all pass).
module ex_mem_stage
    import arm_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  reg_write_enable_in,
    input  logic                  mem_write_enable_in,
    input  logic                  mem_to_reg_select_in,
    input  logic                  status_bits_in,
    input  logic [3:0]            cond_in,
    input  logic [3:0]            alu_flags_in,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    input  logic [DATA_WIDTH-1:0] store_data_in,
    input  logic [REG_WIDTH-1:0]  dest_reg_in,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  valid_out,
    output logic                  reg_write_enable_out,
    output logic                  mem_write_enable_out,
    output logic                  mem_to_reg_select_out,
    output logic [DATA_WIDTH-1:0] alu_result_out,
    output logic [DATA_WIDTH-1:0] store_data_out,
    output logic [REG_WIDTH-1:0]  dest_reg_out,
    output logic [3:0]            flags_out,
    output logic                  cond_pass_out
);

    logic                  valid_q, rwe_q, mwe_q, m2r_q, cond_pass_q;
    logic [DATA_WIDTH-1:0] result_q, store_q;
    logic [REG_WIDTH-1:0]  dest_q;
    logic [3:0]            flags_q;

    logic cond_ok;
    logic cond_pass;
    logic exec;
    logic flag_load;

    // Evaluated against the committed flags so a back-to-back setter sees the previous result.
    cond_check u_cond_check (
        .cond (cond_in),
        .nzcv (flags_q),
        .pass (cond_ok)
    );

`ifdef EX_COND_EXEC_EN
    assign cond_pass = cond_ok;
`else
    logic unused_cond_ok;
    assign unused_cond_ok = cond_ok;
    assign cond_pass      = 1'b1;
`endif

    always_comb begin
        exec      = valid_in && cond_pass;
        flag_load = exec && status_bits_in && !stall && !flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rwe_q       <= 1'b0;
            mwe_q       <= 1'b0;
            m2r_q       <= 1'b0;
            cond_pass_q <= 1'b0;
            result_q    <= '0;
            store_q     <= '0;
            dest_q      <= '0;
        end else if (flush) begin
            // Data and mem_to_reg simply hold; they are meaningless once valid drops.
            valid_q     <= 1'b0;
            rwe_q       <= 1'b0;
            mwe_q       <= 1'b0;
            cond_pass_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= valid_in;
            rwe_q       <= exec && reg_write_enable_in;
            mwe_q       <= exec && mem_write_enable_in;
            m2r_q       <= mem_to_reg_select_in;
            cond_pass_q <= exec;
            result_q    <= alu_result_in;
            store_q     <= store_data_in;
            dest_q      <= dest_reg_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (flag_load) begin
            flags_q <= alu_flags_in;
        end
    end

    assign valid_out             = valid_q;
    assign reg_write_enable_out  = rwe_q;
    assign mem_write_enable_out  = mwe_q;
    assign mem_to_reg_select_out = m2r_q;
    assign alu_result_out        = result_q;
    assign store_data_out        = store_q;
    assign dest_reg_out          = dest_q;
    assign flags_out             = flags_q;
    assign cond_pass_out         = cond_pass_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized traffic vs. a rule model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in, reg_write_enable_in, mem_write_enable_in, mem_to_reg_select_in;
    logic        status_bits_in, stall, flush;
    logic [3:0]  cond_in, alu_flags_in, dest_reg_in;
    logic [31:0] alu_result_in, store_data_in;

    logic        valid_out, reg_write_enable_out, mem_write_enable_out, mem_to_reg_select_out;
    logic        cond_pass_out;
    logic [31:0] alu_result_out, store_data_out;
    logic [3:0]  dest_reg_out, flags_out;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state
    logic        m_valid, m_rwe, m_mwe, m_m2r, m_cp;
    logic [31:0] m_res, m_sd;
    logic [3:0]  m_dest, m_flags;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .valid_in              (valid_in),
        .reg_write_enable_in   (reg_write_enable_in),
        .mem_write_enable_in   (mem_write_enable_in),
        .mem_to_reg_select_in  (mem_to_reg_select_in),
        .status_bits_in        (status_bits_in),
        .cond_in               (cond_in),
        .alu_flags_in          (alu_flags_in),
        .alu_result_in         (alu_result_in),
        .store_data_in         (store_data_in),
        .dest_reg_in           (dest_reg_in),
        .stall                 (stall),
        .flush                 (flush),
        .valid_out             (valid_out),
        .reg_write_enable_out  (reg_write_enable_out),
        .mem_write_enable_out  (mem_write_enable_out),
        .mem_to_reg_select_out (mem_to_reg_select_out),
        .alu_result_out        (alu_result_out),
        .store_data_out        (store_data_out),
        .dest_reg_out          (dest_reg_out),
        .flags_out             (flags_out),
        .cond_pass_out         (cond_pass_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ARM encoding view: pairs share a base test, odd codes invert it, 1111 never passes.
    function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
`ifdef EX_COND_EXEC_EN
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
`else
        n = 0; z = 0; cy = 0; v = 0; base = 1'b1;
        return base;
`endif
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rwe = 0; m_mwe = 0; m_m2r = 0; m_cp = 0;
        m_res = '0; m_sd = '0; m_dest = '0; m_flags = '0;
    endtask

    task automatic model_edge();
        bit ok;
        ok = model_cond(cond_in, m_flags);
        if (reset) begin
            model_reset();
        end else if (flush) begin
            m_valid = 0; m_rwe = 0; m_mwe = 0; m_cp = 0;
        end else if (!stall) begin
            m_valid = valid_in;
            m_rwe   = valid_in && ok && reg_write_enable_in;
            m_mwe   = valid_in && ok && mem_write_enable_in;
            m_cp    = valid_in && ok;
            m_m2r   = mem_to_reg_select_in;
            m_res   = alu_result_in;
            m_sd    = store_data_in;
            m_dest  = dest_reg_in;
            if (valid_in && status_bits_in && ok) m_flags = alu_flags_in;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, {31'b0, valid_out}, {31'b0, m_valid});
        check({tag, ".rwe"},   {31'b0, reg_write_enable_out}, {31'b0, m_rwe});
        check({tag, ".mwe"},   {31'b0, mem_write_enable_out}, {31'b0, m_mwe});
        check({tag, ".m2r"},   {31'b0, mem_to_reg_select_out}, {31'b0, m_m2r});
        check({tag, ".cp"},    {31'b0, cond_pass_out}, {31'b0, m_cp});
        check({tag, ".res"},   alu_result_out, m_res);
        check({tag, ".sd"},    store_data_out, m_sd);
        check({tag, ".dest"},  {28'b0, dest_reg_out}, {28'b0, m_dest});
        check({tag, ".flags"}, {28'b0, flags_out}, {28'b0, m_flags});
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic rwe, input logic mwe, input logic s,
                         input logic [3:0] c, input logic [3:0] af, input logic [31:0] res,
                         input logic [3:0] dst, input logic st, input logic fl);
        valid_in = v; reg_write_enable_in = rwe; mem_write_enable_in = mwe;
        mem_to_reg_select_in = $urandom_range(0, 1); status_bits_in = s;
        cond_in = c; alu_flags_in = af; alu_result_in = res; store_data_in = $urandom;
        dest_reg_in = dst; stall = st; flush = fl;
    endtask

    task automatic drive_random(input logic st, input logic fl);
        logic [3:0] c;
        c = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
        drive(($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom), 1'($urandom), c,
              4'($urandom), $urandom, 4'($urandom), st, fl);
    endtask

    initial begin
        // Reset with every input high must clear outputs before any clock edge.
        drive(1, 1, 1, 1, 4'hF, 4'hF, 32'hFFFF_FFFF, 4'hF, 1, 1);
        mem_to_reg_select_in = 1; store_data_in = 32'hFFFF_FFFF;
        #1 reset = 1'b1;
        model_reset();
        #1 check_all("rst_async");
        step("rst_held");
        reset = 1'b0;

        // First edge after reset: AL ADD r3 = 5
        drive(1, 1, 0, 0, 4'hE, 4'h0, 32'h0000_0005, 4'd3, 0, 0);
        step("add_al");
        check("add_al.valid1", {31'b0, valid_out}, 32'd1);
        check("add_al.rwe1", {31'b0, reg_write_enable_out}, 32'd1);
        check("add_al.dest3", {28'b0, dest_reg_out}, 32'd3);
        check("add_al.res5", alu_result_out, 32'd5);

        // Flags are 0000 here: EQ instruction with S=1
        drive(1, 1, 1, 1, 4'h0, 4'hB, 32'h1234, 4'd7, 0, 0);
        step("eq_z0");
`ifdef EX_COND_EXEC_EN
        check("eq_z0.flags_hold", {28'b0, flags_out}, 32'h0);
        check("eq_z0.rwe0", {31'b0, reg_write_enable_out}, 32'd0);
`else
        check("eq_z0.flags_load", {28'b0, flags_out}, 32'hB);
`endif
        // SUBS AL sets Z, then EQ immediately follows
        drive(1, 1, 0, 1, 4'hE, 4'b0100, 32'h0, 4'd1, 0, 0);
        step("subs");
        check("subs.flags", {28'b0, flags_out}, 32'h4);
        drive(1, 0, 0, 0, 4'h0, 4'h0, 32'h40, 4'd15, 0, 0);
        step("beq");
        check("beq.cp", {31'b0, cond_pass_out}, 32'd1);

        // NV: never under conditional execution, always otherwise
        drive(1, 1, 0, 0, 4'hF, 4'h0, 32'h99, 4'd2, 0, 0);
        step("nv");
`ifdef EX_COND_EXEC_EN
        check("nv.cp", {31'b0, cond_pass_out}, 32'd0);
`else
        check("nv.cp", {31'b0, cond_pass_out}, 32'd1);
        check("nv.rwe", {31'b0, reg_write_enable_out}, 32'd1);
`endif

        // Stall three cycles with changing inputs, then stall+flush together
        drive(1, 1, 1, 1, 4'hE, 4'b1001, 32'hCAFE, 4'd9, 0, 0);
        step("pre_stall");
        for (int i = 0; i < 3; i++) begin
            drive_random(1, 0);
            step("stall");
        end
        drive_random(1, 1);
        valid_in = 1; status_bits_in = 1; cond_in = 4'hE;
        step("stall_flush");
        check("stall_flush.flags", {28'b0, flags_out}, 32'h9);

        // Async reset pulse between edges with valid_out=1 and flags=1010
        drive(1, 1, 0, 1, 4'hE, 4'b1010, 32'hBEEF, 4'd4, 0, 0);
        step("set_1010");
        #2 reset = 1'b1;
        #1 model_reset();
        check_all("rst_mid");
        #1 reset = 1'b0;

        // Reset held across an edge while stall and flush are both high
        drive(1, 1, 1, 1, 4'hE, 4'hF, 32'h77, 4'd5, 1, 1);
        #1 reset = 1'b1;
        step("rst_over_stall");
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive_random(($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
